// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl_pkg
// Brief    : MDUSel encodings, FSM state codes and decode helpers for the MDU.
// Revision : 1.0
// ============================================================================
package mdu_ctrl_pkg;

    typedef logic [2:0] mdu_sel_t;

    localparam mdu_sel_t MULDIV_DO_MUL     = 3'd1;
    localparam mdu_sel_t MULDIV_DO_MULU    = 3'd2;
    localparam mdu_sel_t MULDIV_DO_DIV     = 3'd3;
    localparam mdu_sel_t MULDIV_DO_DIVU    = 3'd4;
    localparam mdu_sel_t MULDIV_SELECT_HI  = 3'd5;
    localparam mdu_sel_t MULDIV_SELECT_LO  = 3'd6;

    localparam logic [0:0] MDU_ST_IDLE = 1'b0;
    localparam logic [0:0] MDU_ST_RUN  = 1'b1;

    function automatic logic sel_is_div(input mdu_sel_t sel);
        return (sel == MULDIV_DO_DIV) || (sel == MULDIV_DO_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module   : mdu_arith
// Brief    : Combinational 64-bit multiply / divide result generator.
// Revision : 1.0
// ============================================================================
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  mdu_sel_t    sel,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_divisor;
    logic        [31:0] w_abs_a;
    logic        [31:0] w_abs_b;
    logic        [31:0] w_q_mag;
    logic        [31:0] w_r_mag;
    logic        [31:0] w_q_u;
    logic        [31:0] w_r_u;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by 1 so the dividers never see /0; the
    // result is discarded by the controller anyway.
    assign w_divisor = (b == 32'd0) ? 32'd1 : b;

    // Signed division via magnitudes: 0x80000000 / -1 falls out as 0x80000000.
    assign w_abs_a = a[31] ? (32'd0 - a) : a;
    assign w_abs_b = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
    assign w_q_mag = w_abs_a / w_abs_b;
    assign w_r_mag = w_abs_a % w_abs_b;
    assign w_q_u   = a / w_divisor;
    assign w_r_u   = a % w_divisor;

    assign div_zero = sel_is_div(sel) && (b == 32'd0);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (sel)
            MULDIV_DO_MUL: begin
                res_hi = w_prod_s[63:32];
                res_lo = w_prod_s[31:0];
            end
            MULDIV_DO_MULU: begin
                res_hi = w_prod_u[63:32];
                res_lo = w_prod_u[31:0];
            end
            MULDIV_DO_DIV: begin
                res_lo = (a[31] ^ w_divisor[31]) ? (32'd0 - w_q_mag) : w_q_mag;
                res_hi = a[31] ? (32'd0 - w_r_mag) : w_r_mag;
            end
            MULDIV_DO_DIVU: begin
                res_lo = w_q_u;
                res_hi = w_r_u;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Brief    : Multi-cycle MDU controller: busy countdown, HI/LO, stall request.
// Revision : 1.0
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e_start,
    input  logic        e_move_to,
    input  logic [2:0]  e_sel,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_uses_mdu,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_load;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_zero;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;
    logic             w_idle;
    logic             w_launch;
    logic             w_commit;

    mdu_arith u_arith (
        .a        (e_a),
        .b        (e_b),
        .sel      (e_sel),
        .res_hi   (w_res_hi),
        .res_lo   (w_res_lo),
        .div_zero (w_div_zero)
    );

    assign w_idle   = (r_state == MDU_ST_IDLE);
    assign w_launch = w_idle && e_start;
    assign w_commit = (r_state == MDU_ST_RUN) && (r_count == CNT_W'(1));
    assign w_load   = sel_is_div(e_sel) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MDU_ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MDU_ST_IDLE: if (e_start)  w_next_state = MDU_ST_RUN;
            MDU_ST_RUN:  if (w_commit) w_next_state = MDU_ST_IDLE;
            default:                   w_next_state = MDU_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == MDU_ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_zero <= 1'b0;
        end else if (w_launch) begin
            r_count     <= w_load;
            r_pend_hi   <= w_res_hi;
            r_pend_lo   <= w_res_lo;
            r_pend_zero <= w_div_zero;
        end else if (!w_idle && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Moves are only honoured in IDLE without a competing start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (w_commit) begin
            if (!r_pend_zero) begin
                hi <= r_pend_hi;
                lo <= r_pend_lo;
            end
        end else if (w_idle && !e_start && e_move_to) begin
            if (e_sel == MULDIV_SELECT_HI) hi <= e_a;
            if (e_sel == MULDIV_SELECT_LO) lo <= e_a;
        end
    end

    assign stall = d_uses_mdu & (busy | e_start);

    always_comb begin
        rd_data = 32'd0;
        if (e_sel == MULDIV_SELECT_HI)      rd_data = hi;
        else if (e_sel == MULDIV_SELECT_LO) rd_data = lo;
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Brief    : Directed self-checking bench for mdu_ctrl.
// Revision : 1.0
// ============================================================================
module tb_mdu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        e_start;
    logic        e_move_to;
    logic [2:0]  e_sel;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_uses_mdu;
    logic        busy;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .e_start    (e_start),
        .e_move_to  (e_move_to),
        .e_sel      (e_sel),
        .e_a        (e_a),
        .e_b        (e_b),
        .d_uses_mdu (d_uses_mdu),
        .busy       (busy),
        .stall      (stall),
        .rd_data    (rd_data),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start/move while busy violates the stall contract.
    always @(posedge clk) begin
        if (rst_n && busy && (e_start || e_move_to)) begin
            errors++;
            $display("FAIL contract: start/move issued while busy=%0b", busy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [2:0] sel, input logic [31:0] a,
                            input logic [31:0] b, output int n);
        @(negedge clk);
        e_start = 1'b1; e_sel = sel; e_a = a; e_b = b;
        @(negedge clk);
        e_start = 1'b0; e_sel = 3'd0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_move(input logic [2:0] sel, input logic [31:0] a);
        @(negedge clk);
        e_move_to = 1'b1; e_sel = sel; e_a = a;
        @(negedge clk);
        e_move_to = 1'b0; e_sel = 3'd0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
        checks++; if (hi !== 32'd0)    begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)    begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        int n;
        start_op(3'd1, 32'hFFFF_FFFF, 32'd2, n);
        checks++; if (n !== 5)                begin errors++; $display("FAIL mult_cycles: got %0d want 5", n); end
        checks++; if (hi !== 32'hFFFF_FFFF)   begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE)   begin errors++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
        start_op(3'd2, 32'hFFFF_FFFF, 32'd2, n);
        checks++; if (n !== 5)                begin errors++; $display("FAIL multu_cycles: got %0d want 5", n); end
        checks++; if (hi !== 32'd1)           begin errors++; $display("FAIL multu_hi: got %h want 1", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE)   begin errors++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_div();
        int n;
        start_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (n !== 10)               begin errors++; $display("FAIL div_cycles: got %0d want 10", n); end
        checks++; if (lo !== 32'hFFFF_FFFD)   begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF)   begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        start_op(3'd4, 32'd7, 32'd2, n);
        checks++; if (n !== 10)               begin errors++; $display("FAIL divu_cycles: got %0d want 10", n); end
        checks++; if (lo !== 32'd3)           begin errors++; $display("FAIL divu_lo: got %h want 3", lo); end
        checks++; if (hi !== 32'd1)           begin errors++; $display("FAIL divu_hi: got %h want 1", hi); end
    endtask

    task automatic test_div_corner();
        int n;
        start_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++; if (lo !== 32'h8000_0000)   begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'd0)           begin errors++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
        do_move(3'd5, 32'h12);
        do_move(3'd6, 32'h34);
        start_op(3'd3, 32'd99, 32'd0, n);
        checks++; if (n !== 10)               begin errors++; $display("FAIL divz_cycles: got %0d want 10", n); end
        checks++; if (hi !== 32'h12)          begin errors++; $display("FAIL divz_hi: got %h want 12", hi); end
        checks++; if (lo !== 32'h34)          begin errors++; $display("FAIL divz_lo: got %h want 34", lo); end
        start_op(3'd4, 32'd99, 32'd0, n);
        checks++; if (lo !== 32'h34)          begin errors++; $display("FAIL divuz_lo: got %h want 34", lo); end
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        e_start = 1'b1; e_sel = 3'd1; e_a = 32'd6; e_b = 32'd7; d_uses_mdu = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start: got %0b want 1", stall); end
        n = 1;
        @(negedge clk);
        e_start = 1'b0; e_sel = 3'd0;
        while (stall && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 6)        begin errors++; $display("FAIL stall_cycles: got %0d want 6", n); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL stall_busy_end: got %0b want 0", busy); end
        d_uses_mdu = 1'b0; e_sel = 3'd6;
        #1;
        checks++; if (rd_data !== 32'd42) begin errors++; $display("FAIL mflo_after_stall: got %h want 2a", rd_data); end
        @(negedge clk);
        e_sel = 3'd0;
        e_start = 1'b1; e_sel = 3'd1; e_a = 32'd2; e_b = 32'd3;
        @(negedge clk);
        e_start = 1'b0; e_sel = 3'd0;
        #1;
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL nomdu_busy: got %0b want 1", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nomdu_stall: got %0b want 0", stall); end
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++; if (lo !== 32'd6)   begin errors++; $display("FAIL nomdu_lo: got %h want 6", lo); end
    endtask

    task automatic test_move();
        do_move(3'd5, 32'hDEAD_BEEF);
        checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi: got %h want deadbeef", hi); end
        checks++; if (lo !== 32'd6)         begin errors++; $display("FAIL mthi_lo: got %h want 6", lo); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mthi_busy: got %0b want 0", busy); end
        e_sel = 3'd5; #1;
        checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hi: got %h want deadbeef", rd_data); end
        e_sel = 3'd6; #1;
        checks++; if (rd_data !== 32'd6)    begin errors++; $display("FAIL rd_lo: got %h want 6", rd_data); end
        e_sel = 3'd1; #1;
        checks++; if (rd_data !== 32'd0)    begin errors++; $display("FAIL rd_none: got %h want 0", rd_data); end
        e_sel = 3'd0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        @(negedge clk);
        e_start = 1'b1; e_sel = 3'd4; e_a = 32'd100; e_b = 32'd7;
        @(negedge clk);
        e_start = 1'b0; e_sel = 3'd0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL rst_pre_busy: got %0b want 1", busy); end
        rst_n = 1'b0; d_uses_mdu = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy: got %0b want 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %0b want 0", stall); end
        checks++; if (hi !== 32'd0)   begin errors++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)   begin errors++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; d_uses_mdu = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (lo !== 32'd0)   begin errors++; $display("FAIL rst_no_commit_lo: got %h want 0", lo); end
        start_op(3'd1, 32'd3, 32'd4, n);
        checks++; if (n !== 5)        begin errors++; $display("FAIL rst_mult_cycles: got %0d want 5", n); end
        checks++; if (lo !== 32'd12)  begin errors++; $display("FAIL rst_mult_lo: got %h want c", lo); end
        checks++; if (hi !== 32'd0)   begin errors++; $display("FAIL rst_mult_hi: got %h want 0", hi); end
    endtask

    initial begin
        rst_n = 1'b0; e_start = 1'b0; e_move_to = 1'b0; e_sel = 3'd0;
        e_a = 32'd0; e_b = 32'd0; d_uses_mdu = 1'b1;
        test_reset();
        d_uses_mdu = 1'b0;
        test_mult();
        test_div();
        test_div_corner();
        test_stall();
        test_move();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
